connect4_move_input: RTL and testbench

Input-conditioning stage directly upstream of `connect4_top`'s game controller. It synchronizes and debounces `BTN_EAST`, and synchronizes the four column-select switches. On each clean button press it encodes the single selected column and offers it as one move over a valid/ready handshake. The game FSM therefore sees exactly one glitch-free move per physical press and never decodes raw switches.

---
 rtl/connect4_move_input.sv | 147 ++++++++++++++
 tb/tb_connect4_move_input.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/connect4_move_input.sv
// connect4_move_input
//   Input conditioning in front of the Connect-4 game controller. Synchronizes
//   and debounces the BTN_EAST push button and synchronizes the four column
//   select switches. Each clean press of the button offers exactly one move
//   (the single selected column) over a valid/ready handshake. Presses with no
//   or multiple switches set, and presses arriving while a move is still
//   pending, are discarded with a one-cycle reject_pulse.
//
// Ports
//   clk           system clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   BTN_EAST      raw bouncy push button, 1 = pressed
//   Switch_0..3   raw column selects for columns 0..3
//   move_ready    controller accepts a move this cycle
//   move_valid    a move is offered
//   move_col      encoded column, frozen while move_valid is high
//   reject_pulse  one-cycle pulse when a press is discarded
//   btn_db        debounced button level
module connect4_move_input #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BTN_EAST,
  input  logic       Switch_0,
  input  logic       Switch_1,
  input  logic       Switch_2,
  input  logic       Switch_3,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_col,
  output logic       reject_pulse,
  output logic       btn_db
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Returns {valid, column}; valid only when exactly one switch is set.
  function automatic logic [2:0] encode_col(input logic [3:0] sw);
    logic [2:0] res;
    case (sw)
      4'b0001: res = {1'b1, 2'd0};
      4'b0010: res = {1'b1, 2'd1};
      4'b0100: res = {1'b1, 2'd2};
      4'b1000: res = {1'b1, 2'd3};
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  logic             btn_s1, btn_s2;
  logic [3:0]       sw_s1, sw_s2;
  logic [CNT_W-1:0] cnt;
  logic             btn_db_q;
  logic             press;
  logic [2:0]       sel;
  state_t           state_q, state_d;
  logic [1:0]       col_d;
  logic             reject_d;

  // Stage: two-flop synchronizers on every raw input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sw_s1  <= 4'b0000;
      sw_s2  <= 4'b0000;
    end else begin
      btn_s1 <= BTN_EAST;
      btn_s2 <= btn_s1;
      sw_s1  <= {Switch_3, Switch_2, Switch_1, Switch_0};
      sw_s2  <= sw_s1;
    end
  end

  // Stage: debounce; the level is accepted once the mismatch has been seen
  // on DEBOUNCE_CYCLES consecutive edges, any agreeing cycle restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s2 != btn_db) begin
        if (cnt == CNT_LAST) begin
          btn_db <= btn_s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = btn_db & ~btn_db_q;
  assign sel   = encode_col(sw_s2);

  // Stage: move offer FSM
  always_comb begin
    state_d  = state_q;
    col_d    = move_col;
    reject_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          if (sel[2]) begin
            state_d = OFFER;
            col_d   = sel[1:0];
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      OFFER: begin
        // A press in OFFER is never queued, even when the handshake
        // completes on the same edge.
        if (move_ready) state_d = IDLE;
        if (press) reject_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      move_col     <= 2'd0;
      reject_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      move_col     <= col_d;
      reject_pulse <= reject_d;
    end
  end

  assign move_valid = (state_q == OFFER);

endmodule

// File: tb/tb_connect4_move_input.sv
module tb_connect4_move_input;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       BTN_EAST = 1'b0;
  logic       Switch_0 = 1'b0, Switch_1 = 1'b0, Switch_2 = 1'b0, Switch_3 = 1'b0;
  logic       move_ready = 1'b0;
  logic       move_valid;
  logic [1:0] move_col;
  logic       reject_pulse;
  logic       btn_db;

  int n_checks = 0;
  int n_fail   = 0;

  int  rej_cnt = 0, vld_rise = 0, width_err = 0, overlap_err = 0;
  logic prev_vld = 1'b0, prev_rej = 1'b0;

  connect4_move_input #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .BTN_EAST(BTN_EAST),
    .Switch_0(Switch_0), .Switch_1(Switch_1), .Switch_2(Switch_2), .Switch_3(Switch_3),
    .move_ready(move_ready), .move_valid(move_valid), .move_col(move_col),
    .reject_pulse(reject_pulse), .btn_db(btn_db)
  );

  always #10 clk = ~clk;

  // Event counters sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (reject_pulse) rej_cnt++;
    if (move_valid && !prev_vld) vld_rise++;
    if (reject_pulse && prev_rej) width_err++;
    if (reject_pulse && move_valid && !prev_vld) overlap_err++;
    prev_vld = move_valid;
    prev_rej = reject_pulse;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input logic [3:0] sw);
    {Switch_3, Switch_2, Switch_1, Switch_0} = sw;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({move_valid, move_col, reject_pulse, btn_db} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_async: outputs=%b required=00000", {move_valid, move_col, reject_pulse, btn_db});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick(2);
    n_checks++;
    if ({move_valid, move_col, reject_pulse, btn_db} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_release: outputs=%b required=00000", {move_valid, move_col, reject_pulse, btn_db});
    end
  endtask

  task automatic test_basic_press();
    set_sw(4'b0100);
    BTN_EAST = 1'b1;
    tick(6);  // after edge 5
    n_checks++;
    if (btn_db !== 1'b1) begin
      n_fail++; $display("FAIL basic_btn_db: got %b required 1", btn_db);
    end
    n_checks++;
    if (move_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_early_valid: got %b required 0", move_valid);
    end
    tick(1);  // after edge 6
    n_checks++;
    if (move_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_valid: got %b required 1", move_valid);
    end
    n_checks++;
    if (move_col !== 2'd2) begin
      n_fail++; $display("FAIL basic_col: got %0d required 2", move_col);
    end
    tick(3);
    n_checks++;
    if (move_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_hold: got %b required 1", move_valid);
    end
    move_ready = 1'b1;
    tick(1);
    move_ready = 1'b0;
    n_checks++;
    if (move_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_handshake: move_valid=%b required 0", move_valid);
    end
  endtask

  task automatic test_release_only();
    int r0, v0;
    r0 = rej_cnt; v0 = vld_rise;
    BTN_EAST = 1'b0;
    tick(5);  // after edge 4
    n_checks++;
    if (btn_db !== 1'b1) begin
      n_fail++; $display("FAIL release_early: btn_db=%b required 1", btn_db);
    end
    tick(1);  // after edge 5
    n_checks++;
    if (btn_db !== 1'b0) begin
      n_fail++; $display("FAIL release_fall: btn_db=%b required 0", btn_db);
    end
    tick(6);
    n_checks++;
    if ((rej_cnt - r0) !== 0 || (vld_rise - v0) !== 0) begin
      n_fail++; $display("FAIL release_events: rejects=%0d moves=%0d required 0 0", rej_cnt - r0, vld_rise - v0);
    end
  endtask

  task automatic test_bounce();
    int r0, v0;
    r0 = rej_cnt; v0 = vld_rise;
    set_sw(4'b0001);
    for (int i = 0; i < 5; i++) begin
      BTN_EAST = 1'b1;
      tick(2);
      n_checks++;
      if (btn_db !== 1'b0) begin
        n_fail++; $display("FAIL bounce_db_hi%0d: btn_db=%b required 0", i, btn_db);
      end
      BTN_EAST = 1'b0;
      tick(2);
      n_checks++;
      if (btn_db !== 1'b0) begin
        n_fail++; $display("FAIL bounce_db_lo%0d: btn_db=%b required 0", i, btn_db);
      end
    end
    tick(8);
    n_checks++;
    if ((rej_cnt - r0) !== 0 || (vld_rise - v0) !== 0 || btn_db !== 1'b0) begin
      n_fail++; $display("FAIL bounce_events: rejects=%0d moves=%0d db=%b required 0 0 0", rej_cnt - r0, vld_rise - v0, btn_db);
    end
    BTN_EAST = 1'b1;
    tick(10);
    BTN_EAST = 1'b0;
    tick(8);
    n_checks++;
    if ((vld_rise - v0) !== 1 || (rej_cnt - r0) !== 0) begin
      n_fail++; $display("FAIL bounce_clean_press: moves=%0d rejects=%0d required 1 0", vld_rise - v0, rej_cnt - r0);
    end
    n_checks++;
    if (move_valid !== 1'b1 || move_col !== 2'd0) begin
      n_fail++; $display("FAIL bounce_clean_col: valid=%b col=%0d required 1 0", move_valid, move_col);
    end
    move_ready = 1'b1;
    tick(1);
    move_ready = 1'b0;
    n_checks++;
    if (move_valid !== 1'b0) begin
      n_fail++; $display("FAIL bounce_handshake: move_valid=%b required 0", move_valid);
    end
  endtask

  task automatic test_invalid_select();
    int r0, v0;
    logic [3:0] pats [2];
    pats[0] = 4'b1001;
    pats[1] = 4'b0000;
    r0 = rej_cnt; v0 = vld_rise;
    for (int i = 0; i < 2; i++) begin
      set_sw(pats[i]);
      BTN_EAST = 1'b1;
      tick(6);
      n_checks++;
      if (reject_pulse !== 1'b0) begin
        n_fail++; $display("FAIL invalid_early%0d: reject=%b required 0", i, reject_pulse);
      end
      tick(1);  // after edge 6
      n_checks++;
      if (reject_pulse !== 1'b1 || move_valid !== 1'b0) begin
        n_fail++; $display("FAIL invalid_reject%0d: reject=%b valid=%b required 1 0", i, reject_pulse, move_valid);
      end
      tick(1);
      n_checks++;
      if (reject_pulse !== 1'b0) begin
        n_fail++; $display("FAIL invalid_width%0d: reject=%b required 0", i, reject_pulse);
      end
      BTN_EAST = 1'b0;
      tick(8);
    end
    n_checks++;
    if ((rej_cnt - r0) !== 2 || (vld_rise - v0) !== 0) begin
      n_fail++; $display("FAIL invalid_events: rejects=%0d moves=%0d required 2 0", rej_cnt - r0, vld_rise - v0);
    end
  endtask

  task automatic test_press_during_offer();
    int r0, v0;
    r0 = rej_cnt; v0 = vld_rise;
    set_sw(4'b0010);
    BTN_EAST = 1'b1;
    tick(7);
    n_checks++;
    if (move_valid !== 1'b1 || move_col !== 2'd1) begin
      n_fail++; $display("FAIL offer_first: valid=%b col=%0d required 1 1", move_valid, move_col);
    end
    BTN_EAST = 1'b0;
    tick(8);
    set_sw(4'b1000);
    BTN_EAST = 1'b1;
    tick(7);
    n_checks++;
    if (reject_pulse !== 1'b1 || move_col !== 2'd1 || move_valid !== 1'b1) begin
      n_fail++; $display("FAIL offer_second: reject=%b col=%0d valid=%b required 1 1 1", reject_pulse, move_col, move_valid);
    end
    BTN_EAST = 1'b0;
    tick(8);
    n_checks++;
    if (move_col !== 2'd1) begin
      n_fail++; $display("FAIL offer_col_frozen: col=%0d required 1", move_col);
    end
    move_ready = 1'b1;
    tick(1);
    move_ready = 1'b0;
    n_checks++;
    if (move_valid !== 1'b0) begin
      n_fail++; $display("FAIL offer_handshake: move_valid=%b required 0", move_valid);
    end
    tick(8);
    n_checks++;
    if ((vld_rise - v0) !== 1 || (rej_cnt - r0) !== 1) begin
      n_fail++; $display("FAIL offer_events: moves=%0d rejects=%0d required 1 1", vld_rise - v0, rej_cnt - r0);
    end
  endtask

  task automatic test_press_at_handshake();
    int v0;
    set_sw(4'b0100);
    BTN_EAST = 1'b1;
    tick(7);
    BTN_EAST = 1'b0;
    tick(8);
    set_sw(4'b0001);
    v0 = vld_rise;
    BTN_EAST = 1'b1;
    tick(6);  // press is active for edge 6
    move_ready = 1'b1;
    tick(1);
    move_ready = 1'b0;
    n_checks++;
    if (move_valid !== 1'b0 || reject_pulse !== 1'b1) begin
      n_fail++; $display("FAIL same_edge: valid=%b reject=%b required 0 1", move_valid, reject_pulse);
    end
    BTN_EAST = 1'b0;
    tick(8);
    n_checks++;
    if (move_valid !== 1'b0 || (vld_rise - v0) !== 0) begin
      n_fail++; $display("FAIL same_edge_not_queued: valid=%b moves=%0d required 0 0", move_valid, vld_rise - v0);
    end
  endtask

  task automatic test_reset_mid_offer();
    set_sw(4'b1000);
    BTN_EAST = 1'b1;
    tick(7);
    n_checks++;
    if (move_valid !== 1'b1 || move_col !== 2'd3) begin
      n_fail++; $display("FAIL rst_pre: valid=%b col=%0d required 1 3", move_valid, move_col);
    end
    #5 rst_n = 1'b0;
    BTN_EAST = 1'b0;
    #2;
    n_checks++;
    if ({move_valid, move_col, reject_pulse, btn_db} !== 5'b0) begin
      n_fail++; $display("FAIL rst_mid_offer: outputs=%b required 00000", {move_valid, move_col, reject_pulse, btn_db});
    end
    #2 rst_n = 1'b1;
    tick(3);
    n_checks++;
    if (move_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle: move_valid=%b required 0", move_valid);
    end
    set_sw(4'b0100);
    BTN_EAST = 1'b1;
    tick(7);
    n_checks++;
    if (move_valid !== 1'b1 || move_col !== 2'd2) begin
      n_fail++; $display("FAIL rst_new_move: valid=%b col=%0d required 1 2", move_valid, move_col);
    end
    move_ready = 1'b1;
    tick(1);
    move_ready = 1'b0;
    BTN_EAST = 1'b0;
    n_checks++;
    if (move_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_new_handshake: move_valid=%b required 0", move_valid);
    end
    tick(8);
  endtask

  task automatic test_pulse_rules();
    n_checks++;
    if (width_err !== 0) begin
      n_fail++; $display("FAIL reject_width: wide pulses=%0d required 0", width_err);
    end
    n_checks++;
    if (overlap_err !== 0) begin
      n_fail++; $display("FAIL reject_overlap: overlaps=%0d required 0", overlap_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic_press();
    test_release_only();
    test_bounce();
    test_invalid_select();
    test_press_during_offer();
    test_press_at_handshake();
    test_reset_mid_offer();
    test_pulse_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
